// File: rtl/gesture_seq_decoder.sv
// Gesture sequence decoder: walks a chain of adjacent hand positions and closes it with word A/B, raising one event per sequence.
// Latency 1 from an accepted code to state_o/ev_*; in_ready drops while an event is pending or in ERROR. Optional GESTURE_TIMEOUT_EN adds an inactivity abandon.
module gesture_seq_decoder #(
    parameter int CODE_W  = 8,
    parameter int N_POS   = 5,
    parameter int SPLIT   = 3,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [CODE_W-1:0] cfg_data,
    input  logic              err_clr,
    output logic [3:0]        state_o,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [1:0]        ev_type,
    output logic [3:0]        ev_pos
);

    localparam int N_ENT = N_POS + 2;

    if (CODE_W < 4 || CODE_W > 16 || N_POS < 2 || N_POS > 14 ||
        SPLIT < 0 || SPLIT > N_POS || TIMEOUT < 1) begin : g_bad_params
        $error("gesture_seq_decoder: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_POS, S_ERR} mode_e;

    mode_e             mode_q;
    logic [3:0]        pos_q;
    logic              ev_valid_q;
    logic [1:0]        ev_type_q;
    logic [3:0]        ev_pos_q;
    logic [CODE_W-1:0] tbl_q [N_ENT];

    function automatic logic [CODE_W-1:0] tbl_default(input int idx);
        logic [15:0] v;
        case (idx)
            0:       v = 16'h0090;
            1:       v = 16'h00A4;
            2:       v = 16'h0082;
            3:       v = 16'h00C7;
            4:       v = 16'h00BA;
            5:       v = 16'h009E;
            6:       v = 16'h008D;
            default: v = 16'hFFFF;
        endcase
        return v[CODE_W-1:0];
    endfunction

    // Scan high to low so the lowest matching index is the one that sticks.
    logic       hit;
    logic [3:0] hit_idx;
    always_comb begin
        hit     = 1'b0;
        hit_idx = 4'd0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (tbl_q[i] == in_code) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

    logic is_pos, is_a, is_b, adj, accept;
    assign is_pos   = hit && (hit_idx < 4'(N_POS));
    assign is_a     = hit && (hit_idx == 4'(N_POS));
    assign is_b     = hit && (hit_idx == 4'(N_POS + 1));
    assign adj      = (hit_idx == pos_q) || (hit_idx == pos_q + 4'd1) ||
                      ((pos_q != 4'd0) && (hit_idx == pos_q - 4'd1));
    assign in_ready = !ev_valid_q && (mode_q != S_ERR);
    assign accept   = in_valid && in_ready;

    always_comb begin
        case (mode_q)
            S_IDLE:  state_o = 4'h0;
            S_POS:   state_o = pos_q + 4'd1;
            default: state_o = 4'hF;
        endcase
    end

    assign ev_valid = ev_valid_q;
    assign ev_type  = ev_type_q;
    assign ev_pos   = ev_pos_q;

`ifdef GESTURE_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] idle_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= S_IDLE;
            pos_q      <= 4'd0;
            ev_valid_q <= 1'b0;
            ev_type_q  <= 2'b00;
            ev_pos_q   <= 4'd0;
            for (int i = 0; i < N_ENT; i++) tbl_q[i] <= tbl_default(i);
`ifdef GESTURE_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
        end else begin
            // Writes land at the edge; this cycle's match already used the old entry.
            for (int i = 0; i < N_ENT; i++) begin
                if (cfg_we && cfg_addr == 4'(i)) tbl_q[i] <= cfg_data;
            end

            if (ev_valid_q && ev_ready) ev_valid_q <= 1'b0;

            if (accept) begin
`ifdef GESTURE_TIMEOUT_EN
                idle_cnt_q <= '0;
`endif
                if (mode_q == S_IDLE) begin
                    if (is_pos) begin
                        mode_q <= S_POS;
                        pos_q  <= hit_idx;
                    end
                end else if (is_pos && adj) begin
                    pos_q <= hit_idx;
                end else if (is_a && pos_q < 4'(SPLIT)) begin
                    mode_q     <= S_IDLE;
                    ev_valid_q <= 1'b1;
                    ev_type_q  <= 2'b01;
                    ev_pos_q   <= pos_q;
                end else if (is_b && pos_q >= 4'(SPLIT)) begin
                    mode_q     <= S_IDLE;
                    ev_valid_q <= 1'b1;
                    ev_type_q  <= 2'b10;
                    ev_pos_q   <= pos_q;
                end else begin
                    mode_q     <= S_ERR;
                    ev_valid_q <= 1'b1;
                    ev_type_q  <= 2'b11;
                    ev_pos_q   <= pos_q;
                end
            end else if (mode_q == S_ERR) begin
                if (err_clr) mode_q <= S_IDLE;
            end
`ifdef GESTURE_TIMEOUT_EN
            else if (mode_q == S_POS) begin
                // Counter parks at TIMEOUT while an event is pending, so the abandon fires once it drains.
                if (idle_cnt_q >= CNT_FIRE && !ev_valid_q) begin
                    mode_q     <= S_IDLE;
                    ev_valid_q <= 1'b1;
                    ev_type_q  <= 2'b00;
                    ev_pos_q   <= pos_q;
                end else if (idle_cnt_q < CNT_MAX) begin
                    idle_cnt_q <= idle_cnt_q + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_gesture_seq_decoder.sv
// Self-checking bench for gesture_seq_decoder: directed scenarios then randomized traffic against a behavioural model.
module tb_gesture_seq_decoder;

    localparam int TO = 8;
`ifdef GESTURE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_code;
    logic       in_ready;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       err_clr;
    logic [3:0] state_o;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_type;
    logic [3:0] ev_pos;

    always #5 clk = ~clk;

    gesture_seq_decoder #(.CODE_W(8), .N_POS(5), .SPLIT(3), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .err_clr(err_clr),
        .state_o(state_o), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_type(ev_type), .ev_pos(ev_pos)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: state held as the state_o encoding, table as plain ints, event as a one-slot buffer.
    int m_tbl [7];
    int m_st, m_evt, m_evp, m_idle;
    bit m_evv;

    task automatic m_reset();
        m_tbl = '{'h90, 'hA4, 'h82, 'hC7, 'hBA, 'h9E, 'h8D};
        m_st = 0; m_evv = 0; m_evt = 0; m_evp = 0; m_idle = 0;
    endtask

    function automatic int m_match(input int code);
        for (int k = 0; k < 7; k++) if (m_tbl[k] == code) return k;
        return -1;
    endfunction

    task automatic m_event(input int t, input int p);
        m_evv = 1; m_evt = t; m_evp = p;
    endtask

    task automatic drive_cycle(input bit v, input int code, input bit rdy, input bit clr,
                               input bit we, input int a, input int d, input bit r);
        bit rdy_m, acc, evv_was;
        int idx, k;
        in_valid = v; in_code = 8'(code); ev_ready = rdy; err_clr = clr;
        cfg_we = we; cfg_addr = 4'(a); cfg_data = 8'(d); rst = r;
        rdy_m = !m_evv && (m_st != 15);
        @(negedge clk);
        chk("state_o", 32'(state_o), 32'(m_st));
        chk("in_ready", 32'(in_ready), 32'(rdy_m));
        chk("ev_valid", 32'(ev_valid), 32'(m_evv));
        if (m_evv) begin
            chk("ev_type", 32'(ev_type), 32'(m_evt));
            chk("ev_pos", 32'(ev_pos), 32'(m_evp));
        end
        if (r) begin
            m_reset();
        end else begin
            acc = v && rdy_m;
            idx = m_match(code);
            evv_was = m_evv;
            if (m_evv && rdy) m_evv = 0;
            if (acc) begin
                m_idle = 0;
                if (m_st == 0) begin
                    if (idx >= 0 && idx < 5) m_st = idx + 1;
                end else begin
                    k = m_st - 1;
                    if (idx >= 0 && idx < 5 && idx - k <= 1 && k - idx <= 1) m_st = idx + 1;
                    else if (idx == 5 && k < 3) begin m_event(1, k); m_st = 0; end
                    else if (idx == 6 && k >= 3) begin m_event(2, k); m_st = 0; end
                    else begin m_event(3, k); m_st = 15; end
                end
            end else if (m_st == 15) begin
                if (clr) m_st = 0;
            end else if (m_st != 0) begin
                m_idle++;
                if (TO_EN && m_idle >= TO && !evv_was) begin
                    m_event(0, m_st - 1);
                    m_st = 0;
                end
            end
            if (we && a < 7) m_tbl[a] = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int code);
        drive_cycle(1, code, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, rdy, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_code = 0; ev_ready = 0; err_clr = 0;
        cfg_we = 0; cfg_addr = 0; cfg_data = 0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_ev_valid", 32'(ev_valid), 0);
        chk("rst_ev_type", 32'(ev_type), 0);
        chk("rst_ev_pos", 32'(ev_pos), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        // Word A closes a left-side chain
        send('h90); send('hA4); send('h9E); idle(2, 1);

        // Non-adjacent jump -> sticky ERROR, cleared only by err_clr
        send('h90); send('h82); send('h90); idle(2, 1);
        chk("err_sticky", 32'(state_o), 'hF);
        chk("err_in_ready", 32'(in_ready), 0);
        drive_cycle(0, 0, 1, 1, 0, 0, 0, 0);
        chk("err_cleared", 32'(state_o), 0);
        idle(1, 1);

        // Word B with back-pressure on the event
        drive_cycle(1, 'hC7, 0, 0, 0, 0, 0, 0);
        drive_cycle(1, 'hBA, 0, 0, 0, 0, 0, 0);
        drive_cycle(1, 'h8D, 0, 0, 0, 0, 0, 0);
        drive_cycle(1, 'h90, 0, 0, 0, 0, 0, 0);
        idle(3, 0);
        chk("stall_ev_valid", 32'(ev_valid), 1);
        chk("stall_ev_type", 32'(ev_type), 2);
        chk("stall_ev_pos", 32'(ev_pos), 4);
        chk("stall_in_ready", 32'(in_ready), 0);
        idle(2, 1);

        // Reprogram position 0; old code no longer recognised
        drive_cycle(0, 0, 1, 0, 1, 0, 'h11, 0);
        drive_cycle(0, 0, 1, 0, 1, 9, 'h90, 0);
        send('h11); send('hA4); send('h9E); idle(1, 1);
        send('h90); idle(1, 1);
        chk("reprog_old_code", 32'(state_o), 0);

        // Reset mid-sequence, then with an event pending
        send('h11); send('hA4); send('h82);
        drive_cycle(0, 0, 1, 0, 1, 1, 'h55, 1);
        idle(1, 1);
        send('h90); idle(1, 1);
        chk("post_rst_table", 32'(state_o), 1);
        drive_cycle(1, 'hC7, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 1, 0, 0, 0, 1);
        idle(1, 1);

        // Inactivity in POS(4)
        send('hBA); idle(TO, 1);
        chk("timeout_state", 32'(state_o), TO_EN ? 0 : 5);
        send('h8D); idle(2, 1);

        for (int n = 0; n < 3000; n++) begin
            int code, a, d;
            if ($urandom_range(9) < 8) code = m_tbl[$urandom_range(6)];
            else code = $urandom_range(255);
            a = $urandom_range(15);
            d = ($urandom_range(1) == 0) ? m_tbl[$urandom_range(6)] : $urandom_range(255);
            drive_cycle($urandom_range(9) < 7, code, $urandom_range(9) < 7,
                        $urandom_range(9) == 0, $urandom_range(49) == 0, a, d,
                        $urandom_range(199) == 0);
            if ($urandom_range(19) == 0) idle($urandom_range(TO + 2), 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
